// File: rtl/trigger_flash_checker.sv
// rtl/trigger_flash_checker.sv - flashing trigger-bit finder with lock/unlock hysteresis
// Searches for a once-per-orbit trigger marker, confirms it, then reports each recurrence.
module trigger_flash_checker #(
  parameter int ORBIT_LEN    = 3564,
  parameter int BCID_W       = 12,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 toggleMode,
  input  logic                 clearErr,
  output logic                 synched,
  output logic                 flashBitFlag,
  output logic                 error,
  output logic [BCID_W-1:0]    flashPos,
  output logic [ERR_CNT_W-1:0] errCnt
);

  localparam int MC_W = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT + 1)   : 1;
  localparam int UC_W = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT + 1) : 1;
  localparam logic [BCID_W-1:0] LAST_BCID  = BCID_W'(ORBIT_LEN - 1);
  localparam logic [MC_W-1:0]   LOCK_LAST  = MC_W'(LOCK_COUNT - 1);
  localparam logic [UC_W-1:0]   UNLOCK_LAST = UC_W'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {S_SEARCH, S_CONFIRM, S_LOCKED} state_t;

  state_t              r_state, w_next_state;
  logic [BCID_W-1:0]   r_bcid;
  logic [BCID_W-1:0]   r_flash_pos;
  logic                r_exp_phase;
  logic [MC_W-1:0]     r_match_cnt, w_next_match;
  logic [UC_W-1:0]     r_miss_cnt, w_next_miss;
  logic                r_toggle_prev;
  logic                r_synched, r_flag, r_error;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic w_tog_change, w_check, w_expected, w_match;
  logic w_capture, w_flag, w_err;

  assign w_tog_change = (toggleMode != r_toggle_prev);
  assign w_check      = (r_state != S_SEARCH) && (r_bcid == r_flash_pos);
  assign w_expected   = toggleMode ? r_exp_phase : 1'b1;
  assign w_match      = (trigger == w_expected);

  always_comb begin
    w_next_state = r_state;
    w_next_match = r_match_cnt;
    w_next_miss  = r_miss_cnt;
    w_capture    = 1'b0;
    w_flag       = 1'b0;
    w_err        = 1'b0;
    // A mode change invalidates any expectation built so far.
    if (w_tog_change) begin
      w_next_state = S_SEARCH;
      w_next_match = '0;
      w_next_miss  = '0;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (trigger) begin
            w_capture    = 1'b1;
            w_next_state = S_CONFIRM;
            w_next_match = '0;
            w_next_miss  = '0;
          end
        end
        S_CONFIRM: begin
          if (w_check) begin
            if (!w_match) begin
              w_next_state = S_SEARCH;
            end else if (r_match_cnt == LOCK_LAST) begin
              w_next_state = S_LOCKED;
              w_next_miss  = '0;
            end else begin
              w_next_match = r_match_cnt + 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (w_check) begin
            if (w_match) begin
              w_flag      = 1'b1;
              w_next_miss = '0;
            end else begin
              w_err = 1'b1;
              if (r_miss_cnt == UNLOCK_LAST) begin
                w_next_state = S_SEARCH;
                w_next_miss  = '0;
                w_next_match = '0;
              end else begin
                w_next_miss = r_miss_cnt + 1'b1;
              end
            end
          end
        end
        default: w_next_state = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_SEARCH;
      r_bcid        <= '0;
      r_flash_pos   <= '0;
      r_exp_phase   <= 1'b0;
      r_match_cnt   <= '0;
      r_miss_cnt    <= '0;
      r_toggle_prev <= toggleMode;
      r_synched     <= 1'b0;
      r_flag        <= 1'b0;
      r_error       <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_bcid        <= (r_bcid == LAST_BCID) ? '0 : r_bcid + 1'b1;
      r_state       <= w_next_state;
      r_match_cnt   <= w_next_match;
      r_miss_cnt    <= w_next_miss;
      r_toggle_prev <= toggleMode;
      r_synched     <= (w_next_state == S_LOCKED);
      r_flag        <= w_flag;
      r_error       <= w_err;
      if (w_capture) begin
        r_flash_pos <= r_bcid;
        r_exp_phase <= 1'b0;
      end else if (w_check && !w_tog_change) begin
        r_exp_phase <= ~r_exp_phase;
      end
      // Clear wins over a coincident error so that error is not counted.
      if (clearErr) begin
        r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign synched      = r_synched;
  assign flashBitFlag = r_flag;
  assign error        = r_error;
  assign flashPos     = r_flash_pos;
  assign errCnt       = r_err_cnt;

endmodule

// File: tb/tb_trigger_flash_checker.sv
// tb/tb_trigger_flash_checker.sv - orbit-level vector table with scoreboard for trigger_flash_checker
module tb_trigger_flash_checker;

  logic       clk = 1'b0;
  logic       rst, trigger, toggleMode, clearErr;
  logic       synched, flashBitFlag, error;
  logic [3:0] flashPos;
  logic [2:0] errCnt;

  always #5 clk = ~clk;

  trigger_flash_checker #(
    .ORBIT_LEN(16), .BCID_W(4), .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .toggleMode(toggleMode), .clearErr(clearErr),
    .synched(synched), .flashBitFlag(flashBitFlag), .error(error),
    .flashPos(flashPos), .errCnt(errCnt)
  );

  typedef struct {
    logic       tog;
    logic [3:0] pos;
    logic       val;
    int         extra;
    logic       clr;
    int         e_flags;
    int         e_errs;
    logic       e_sync;
    logic [3:0] e_pos;
    logic [2:0] e_cnt;
  } vec_t;

  typedef struct {
    int         flags;
    int         errs;
    logic       sync;
    logic [3:0] pos;
    logic [2:0] cnt;
  } exp_t;

  vec_t vecs[42];
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   obs_flags, obs_errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void sv(input int i, input logic tog, input logic [3:0] pos, input logic val,
                             input int extra, input logic clr, input int f, input int e,
                             input logic s, input logic [3:0] p, input logic [2:0] c);
    vecs[i] = '{tog, pos, val, extra, clr, f, e, s, p, c};
  endfunction

  task automatic cycle(input logic trig);
    trigger = trig;
    @(posedge clk);
    #1;
    if (flashBitFlag) obs_flags++;
    if (error)        obs_errs++;
    @(negedge clk);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      exp_t x;
      logic trig;
      v = vecs[i];
      x.flags = v.e_flags; x.errs = v.e_errs; x.sync = v.e_sync; x.pos = v.e_pos; x.cnt = v.e_cnt;
      sb_q.push_back(x);
      toggleMode = v.tog;
      obs_flags = 0;
      obs_errs  = 0;
      for (int b = 0; b < 16; b++) begin
        trig = (b == int'(v.pos)) ? v.val : 1'b0;
        if (b == v.extra) trig = 1'b1;
        clearErr = v.clr && ((b == int'(v.pos)) || (b == (int'(v.pos) + 1) % 16));
        cycle(trig);
      end
      clearErr = 1'b0;
      x = sb_q.pop_front();
      check($sformatf("v%0d flags", i),   obs_flags, x.flags);
      check($sformatf("v%0d errors", i),  obs_errs,  x.errs);
      check($sformatf("v%0d synched", i), synched,   x.sync);
      check($sformatf("v%0d flashPos", i), flashPos, x.pos);
      check($sformatf("v%0d errCnt", i),  errCnt,    x.cnt);
    end
  endtask

  initial begin
    // Constant mode, flash at 5: lock, short dropout, long dropout, relock, saturation, clear.
    sv( 0, 0, 5, 1, -1, 0, 0, 0, 0, 5, 0);
    sv( 1, 0, 5, 1, -1, 0, 0, 0, 0, 5, 0);
    sv( 2, 0, 5, 1, -1, 0, 0, 0, 0, 5, 0);
    sv( 3, 0, 5, 1, -1, 0, 0, 0, 0, 5, 0);
    sv( 4, 0, 5, 1, -1, 0, 0, 0, 1, 5, 0);
    sv( 5, 0, 5, 1, -1, 0, 1, 0, 1, 5, 0);
    sv( 6, 0, 5, 1, -1, 0, 1, 0, 1, 5, 0);
    sv( 7, 0, 5, 0, -1, 0, 0, 1, 1, 5, 1);
    sv( 8, 0, 5, 0, -1, 0, 0, 1, 1, 5, 2);
    sv( 9, 0, 5, 1, -1, 0, 1, 0, 1, 5, 2);
    sv(10, 0, 5, 0, -1, 0, 0, 1, 1, 5, 3);
    sv(11, 0, 5, 0, -1, 0, 0, 1, 1, 5, 4);
    sv(12, 0, 5, 0, -1, 0, 0, 1, 0, 5, 5);
    sv(13, 0, 5, 1, -1, 0, 0, 0, 0, 5, 5);
    sv(14, 0, 5, 1, -1, 0, 0, 0, 0, 5, 5);
    sv(15, 0, 5, 1, -1, 0, 0, 0, 0, 5, 5);
    sv(16, 0, 5, 1, -1, 0, 0, 0, 0, 5, 5);
    sv(17, 0, 5, 1, -1, 0, 0, 0, 1, 5, 5);
    sv(18, 0, 5, 1, -1, 0, 1, 0, 1, 5, 5);
    sv(19, 0, 5, 0, -1, 0, 0, 1, 1, 5, 6);
    sv(20, 0, 5, 0, -1, 0, 0, 1, 1, 5, 7);
    sv(21, 0, 5, 1, -1, 0, 1, 0, 1, 5, 7);
    sv(22, 0, 5, 0, -1, 0, 0, 1, 1, 5, 7);
    sv(23, 0, 5, 1, -1, 0, 1, 0, 1, 5, 7);
    sv(24, 0, 5, 0, -1, 1, 0, 1, 1, 5, 0);
    sv(25, 0, 5, 1, -1, 0, 1, 0, 1, 5, 0);
    // Toggle mode, flash at the wrap position 15, extra 1 injected in a 0 orbit.
    sv(26, 1, 15, 1, -1, 0, 0, 0, 0, 15, 0);
    sv(27, 1, 15, 0, -1, 0, 0, 0, 0, 15, 0);
    sv(28, 1, 15, 1, -1, 0, 0, 0, 0, 15, 0);
    sv(29, 1, 15, 0, -1, 0, 0, 0, 0, 15, 0);
    sv(30, 1, 15, 1, -1, 0, 0, 0, 1, 15, 0);
    sv(31, 1, 15, 0, -1, 0, 1, 0, 1, 15, 0);
    sv(32, 1, 15, 1, -1, 0, 1, 0, 1, 15, 0);
    sv(33, 1, 15, 1, -1, 0, 0, 1, 1, 15, 1);
    sv(34, 1, 15, 1, -1, 0, 1, 0, 1, 15, 1);
    // Spurious trigger at 2 in the first orbit only, real flash at 9.
    sv(35, 0, 9, 1,  2, 0, 0, 0, 0, 2, 0);
    sv(36, 0, 9, 1, -1, 0, 0, 0, 0, 9, 0);
    sv(37, 0, 9, 1, -1, 0, 0, 0, 0, 9, 0);
    sv(38, 0, 9, 1, -1, 0, 0, 0, 0, 9, 0);
    sv(39, 0, 9, 1, -1, 0, 0, 0, 0, 9, 0);
    sv(40, 0, 9, 1, -1, 0, 0, 0, 1, 9, 0);
    sv(41, 0, 9, 1, -1, 0, 1, 0, 1, 9, 0);

    rst = 1'b1; trigger = 1'b0; toggleMode = 1'b0; clearErr = 1'b0;
    obs_flags = 0; obs_errs = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset synched",  synched,      0);
    check("reset flag",     flashBitFlag, 0);
    check("reset error",    error,        0);
    check("reset flashPos", flashPos,     0);
    check("reset errCnt",   errCnt,       0);
    rst = 1'b0;
    apply(0, 25);

    // One-cycle reset while locked, landing on the check cycle itself.
    for (int b = 0; b < 5; b++) cycle(1'b0);
    rst = 1'b1;
    obs_flags = 0; obs_errs = 0;
    cycle(1'b1);
    check("midrst synched",  synched,      0);
    check("midrst flag",     obs_flags,    0);
    check("midrst error",    error,        0);
    check("midrst flashPos", flashPos,     0);
    check("midrst errCnt",   errCnt,       0);
    toggleMode = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    apply(26, 34);

    // Mode flip while locked drops lock but keeps the error count.
    for (int b = 0; b < 3; b++) cycle(1'b0);
    toggleMode = 1'b0;
    obs_flags = 0; obs_errs = 0;
    cycle(1'b0);
    check("modeflip synched", synched,   0);
    check("modeflip errCnt",  errCnt,    1);
    check("modeflip flag",    obs_flags, 0);
    rst = 1'b1;
    cycle(1'b0);
    rst = 1'b0;
    apply(35, 41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_flash_checker.md
Name: trigger_flash_checker

Overview:
- Parametrised successor to the single-orbit trigger checker.
- Monitors one trigger bit per 40 MHz bunch crossing (BC) and finds the flashing bit, a trigger marker that recurs at a fixed BCID once per orbit.
- Locks onto the flashing bit, then reports each correct or failed recurrence.
- Supports constant-1 and toggling flash modes, programmable lock/unlock hysteresis and a saturating error counter.
- Sits after the trigger deserialiser; feeds the status registers.

Parameters:
- ORBIT_LEN, 3564, BCs per orbit (>=4).
- BCID_W, 12, width of BCID counter and flashPos; must satisfy 2^BCID_W >= ORBIT_LEN.
- LOCK_COUNT, 4, consecutive correct recurrences after the candidate is found before synched asserts (>=1).
- UNLOCK_COUNT, 3, consecutive failed recurrences in LOCKED before lock is dropped (>=1).
- ERR_CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  40 MHz BC clock.
- rst  in  1  synchronous reset, active-high.
- trigger  in  1  trigger bit for the current BC.
- toggleMode  in  1  0: flash bit is 1 every orbit; 1: flash bit alternates 1/0 each orbit.
- clearErr  in  1  synchronous clear of errCnt.
- synched  out  1  high while LOCKED.
- flashBitFlag  out  1  one-cycle pulse per correct flash check in LOCKED.
- error  out  1  one-cycle pulse per failed flash check in LOCKED.
- flashPos  out  BCID_W  BCID of the current candidate / locked flash bit.
- errCnt  out  ERR_CNT_W  saturating count of error pulses.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values: synched=0, flashBitFlag=0, error=0, flashPos=0, errCnt=0, bcid=0, state=SEARCH.
- bcid: free-running 0..ORBIT_LEN-1; wraps to 0 after ORBIT_LEN-1; never stops outside reset.
- Check cycle: a cycle with state!=SEARCH and bcid==flashPos. Expected value at a check cycle: 1 if toggleMode=0; expPhase if toggleMode=1.
- expPhase: toggles on every check cycle, match or not.
- SEARCH:
  - On the first cycle with trigger=1, latch flashPos=bcid and set expPhase=0 (the next expected value in toggle mode).
  - Go to CONFIRM with matchCnt=0.
- CONFIRM, at each check cycle:
  - Match: matchCnt++. When matchCnt reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: go to SEARCH. The search resumes on the next cycle, so the scan advances past the failed candidate.
  - No error pulses are issued in CONFIRM.
- LOCKED, at each check cycle:
  - Match: flashBitFlag=1 for one cycle; missCnt=0.
  - Mismatch: error=1 for one cycle; errCnt++; missCnt++.
  - When missCnt reaches UNLOCK_COUNT, go to SEARCH and deassert synched.
- Triggers at non-check BCIDs are ignored in CONFIRM and LOCKED.
- Latency:
  - All outputs are registered.
  - flashBitFlag/error assert the cycle after the check cycle.
  - synched rises the cycle after the LOCK_COUNT-th match and falls the cycle after the UNLOCK_COUNT-th consecutive miss.
  - flashPos updates the cycle after the SEARCH capture.
- errCnt:
  - Saturates at 2^ERR_CNT_W-1.
  - clearErr has priority: if clearErr and error coincide, errCnt=0 and that error is not counted.
  - errCnt is unaffected by lock loss.
- A toggleMode change (sampled value differs from the previous cycle) forces SEARCH the next cycle. matchCnt, missCnt and synched clear; errCnt is kept.
- Wrap-around: a candidate at bcid=ORBIT_LEN-1 is legal; the check fires at bcid=ORBIT_LEN-1 of the next orbit.
- Capture rule: a trigger in the same cycle the FSM enters SEARCH is not captured; capture starts the cycle after entry.
- Reset mid-operation returns all state to reset values on the next edge, regardless of state.

Test Plan:
- ORBIT_LEN=16, LOCK_COUNT=4, toggleMode=0, trigger=1 only at bcid 5 each orbit -> flashPos=5; synched rises 1 cycle after the 5th occurrence (orbit 4 check); flashBitFlag then pulses once per orbit; errCnt=0.
- Same setup, locked, then drop the flash bit for 2 orbits and restore it -> error pulses twice, errCnt=2, synched stays 1. Drop it for 3 orbits -> synched falls after the 3rd miss, FSM re-acquires bcid 5.
- toggleMode=1, trigger pattern 1,0,1,0,... at bcid 15 (wrap position) -> lock with flashPos=15. Inject an extra 1 in a 0 orbit -> one error pulse.
- Random trigger at bcid 2 in orbit 0 only, flash at bcid 9 -> candidate 2 fails in CONFIRM with no error pulse; capture moves to 9; lock achieved.
- errCnt at 0xFFFF with a miss -> stays 0xFFFF. clearErr coincident with an error pulse -> errCnt=0.
- rst asserted while LOCKED for 1 cycle -> next cycle all outputs 0, bcid=0, state SEARCH. Also, toggleMode flip while LOCKED -> synched=0 next cycle, errCnt unchanged.
